// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states, fault check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StMerge,
      StWr,
      StResp
   } lsu_state_t;

   // oor: byte offset lies outside the memory window.
   function automatic logic lsu_fault(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lane,
                                      input logic       oor);
      logic f;
      f = oor;
      case (funct3)
         F3_B:  f = f;
         F3_H:  f = f | lane[0];
         F3_W:  f = f | (lane != 2'b00);
         F3_BU: f = f | we;
         F3_HU: f = f | we | lane[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extract with sign/zero extend, store lane merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] ld_word,
   input  logic [31:0] st_word,
   input  logic [31:0] st_data,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = ld_word[{lane, 3'b000} +: 8];
      half_sel  = ld_word[{lane[1], 4'b0000} +: 16];
      load_data = 32'h0;
      case (funct3)
         F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU: load_data = {24'h0, byte_sel};
         F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU: load_data = {16'h0, half_sel};
         F3_W:  load_data = ld_word;
         default: load_data = 32'h0;
      endcase
   end

   always_comb begin
      merged = st_word;
      case (funct3)
         F3_B: merged[{lane, 3'b000} +: 8] = st_data[7:0];
         F3_H: merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
         default: merged = st_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed RISC-V requests and drives a word-addressed memory,
// doing read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR      = 32'h0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [2:0]                req_funct3,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      resp_valid,
   output logic [31:0]               resp_rdata,
   output logic                      resp_fault,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic [31:0]               mem_rdata,
   output logic                      mem_write_enable,
   output logic                      mem_read_enable
);

   lsu_state_t  state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;

   logic [31:0] off;
   logic        oor;
   logic        fault;
   logic [31:0] load_data;
   logic [31:0] merged;

   // BASE_ADDR is word-aligned, so off[1:0] equals req_addr[1:0].
   assign off       = req_addr - BASE_ADDR;
   assign oor       = |off[31:MEM_ADDR_WIDTH+2];
   assign fault     = lsu_fault(req_we, req_funct3, off[1:0], oor);
   assign req_ready = (state_q == StIdle);

   lsu_align u_align (
      .funct3    (funct3_q),
      .lane      (lane_q),
      .ld_word   (mem_rdata),
      .st_word   (word_q),
      .st_data   (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= StIdle;
         we_q             <= 1'b0;
         funct3_q         <= 3'd0;
         lane_q           <= 2'd0;
         wdata_q          <= 32'h0;
         word_q           <= 32'h0;
         resp_valid       <= 1'b0;
         resp_rdata       <= 32'h0;
         resp_fault       <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= 32'h0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
      end else begin
         resp_valid       <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  funct3_q   <= req_funct3;
                  lane_q     <= off[1:0];
                  wdata_q    <= req_wdata;
                  resp_rdata <= 32'h0;
                  if (fault) begin
                     resp_fault <= 1'b1;
                     resp_valid <= 1'b1;
                     state_q    <= StResp;
                  end else begin
                     mem_addr <= off[MEM_ADDR_WIDTH+1:2];
                     // Full-word stores skip the read; everything else reads first.
                     if (req_we && req_funct3 == F3_W) begin
                        mem_wdata        <= req_wdata;
                        mem_write_enable <= 1'b1;
                        state_q          <= StWr;
                     end else begin
                        mem_read_enable <= 1'b1;
                        state_q         <= StRd;
                     end
                  end
               end
            end
            StRd: state_q <= StRdWait;
            StRdWait: begin
               if (we_q) begin
                  word_q  <= mem_rdata;
                  state_q <= StMerge;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state_q    <= StResp;
               end
            end
            StMerge: begin
               mem_wdata        <= merged;
               mem_write_enable <= 1'b1;
               state_q          <= StWr;
            end
            StWr: begin
               resp_valid <= 1'b1;
               state_q    <= StResp;
            end
            StResp: begin
               resp_fault <= 1'b0;
               resp_rdata <= 32'h0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-addressed memory model attached.
module tb_load_store_unit;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_fault;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_write_enable;
   logic          mem_read_enable;

   load_store_unit #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_fault       (resp_fault),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem_model [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_write_enable) mem_model[mem_addr] <= mem_wdata;
      if (mem_read_enable) mem_rdata <= mem_model[mem_addr];
   end

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          due;
      int          nrd;
      int          nwr;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   exp_t eq[$];
   wr_t  wq[$];
   int   checks = 0;
   int   passes = 0;
   int   rd_seen = 0;
   int   wr_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   // Monitor: pops the scoreboard on every response and checks every memory write.
   always @(negedge clk) begin
      if (!rst) begin
         rd_seen = 0;
         wr_seen = 0;
      end else begin
         if (mem_read_enable || mem_write_enable)
            chk("enable_overlap", {31'h0, mem_read_enable & mem_write_enable}, 32'h0);
         if (mem_read_enable) rd_seen++;
         if (mem_write_enable) begin
            wr_seen++;
            if (wq.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
            else begin
               wr_t w;
               w = wq.pop_front();
               chk("wr_addr", {22'h0, mem_addr}, {22'h0, w.addr});
               chk("wr_data", mem_wdata, w.data);
            end
         end
         if (resp_valid) begin
            if (eq.size() == 0) chk("unexpected_resp", 32'h1, 32'h0);
            else begin
               exp_t e;
               e = eq.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
               chk("resp_cycle", cyc, e.due);
               chk("read_strobes", rd_seen, e.nrd);
               chk("write_strobes", wr_seen, e.nwr);
            end
            rd_seen = 0;
            wr_seen = 0;
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit track, input logic [31:0] erd,
                        input bit eflt, input int lat, input int nrd, input int nwr);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      if (track) eq.push_back('{erd, eflt, cyc + lat, nrd, nwr});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'h0, 1'b1, exp, 1'b0, 3, 1, 0);
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] word_after);
      wq.push_back('{addr[AW+1:2], word_after});
      if (f3 == 3'd2) issue(1'b1, f3, addr, data, 1'b1, 32'h0, 1'b0, 2, 0, 1);
      else issue(1'b1, f3, addr, data, 1'b1, 32'h0, 1'b0, 5, 1, 1);
   endtask

   task automatic flt(input bit we, input logic [2:0] f3, input logic [31:0] addr);
      issue(we, f3, addr, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1, 0, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (eq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (eq.size() != 0) begin
         chk("drain_timeout", eq.size(), 32'h0);
         eq.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, "_resp_fault"}, {31'h0, resp_fault}, 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_mem_addr"}, {22'h0, mem_addr}, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_mem_we"}, {31'h0, mem_write_enable}, 32'h0);
      chk({tag, "_mem_re"}, {31'h0, mem_read_enable}, 32'h0);
      chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_model[i] = 32'h0;
      mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      st(3'd2, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      ld(3'd2, 32'h10, 32'hDEAD_BEEF);
      st(3'd0, 32'h11, 32'h0000_0055, 32'hDEAD_55EF);
      ld(3'd4, 32'h11, 32'h0000_0055);
      ld(3'd0, 32'h13, 32'hFFFF_FFDE);
      ld(3'd1, 32'h12, 32'hFFFF_DEAD);
      ld(3'd5, 32'h12, 32'h0000_DEAD);
      ld(3'd2, 32'h10, 32'hDEAD_55EF);

      flt(1'b0, 3'd2, 32'h12);
      flt(1'b1, 3'd1, 32'h11);
      flt(1'b1, 3'd2, 32'h1000);
      flt(1'b0, 3'd3, 32'h10);
      flt(1'b0, 3'd6, 32'h10);
      flt(1'b1, 3'd3, 32'h10);
      flt(1'b1, 3'd4, 32'h10);
      flt(1'b0, 3'd0, 32'hFFFF_FFFF);

      st(3'd1, 32'h22, 32'hABCD_1234, 32'h1234_0000);
      ld(3'd1, 32'h22, 32'h0000_1234);
      ld(3'd2, 32'h20, 32'h1234_0000);
      st(3'd2, 32'hFFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      ld(3'd2, 32'hFFC, 32'hA5A5_A5A5);
      ld(3'd0, 32'hFFF, 32'hFFFF_FFA5);
      drain();
      chk("word4_after_faults", mem_model[4], 32'hDEAD_55EF);

      // Abandon an SB while it sits in the merge cycle.
      issue(1'b1, 3'd0, 32'h10, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_idle_outputs("midop_reset");
      repeat (3) @(negedge clk);
      chk("word4_after_reset", mem_model[4], 32'hDEAD_55EF);
      rst = 1'b1;
      @(negedge clk);
      ld(3'd2, 32'h10, 32'hDEAD_55EF);
      drain();
      chk("write_queue_empty", wq.size(), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
